// File: rtl/spi_slave_if_pkg.sv
// Shared types and constants for the SPI slave front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

    localparam int FRAME_W_DEF = 10;
    localparam int DATA_W_DEF  = 8;

    // Frame-level FSM states of the slave
    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

    // Command field encodings (frame bits [9:8]); forwarded verbatim to the RAM
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_if_if.sv
// SPI pins plus the RAM-facing word/response signals of the slave front end.
// Latency: n/a (wiring only).
// Backpressure: none; SS_n framing and tx_valid strobes only.
interface spi_slave_if_if #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
);
    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    // SPI master and RAM side
    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

    // The slave front end
    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_miso_serializer.sv
// Loads one DATA_W response word and shifts it out on MISO, MSB first, once per load.
// Latency: MSB on MISO the edge after load, remaining bits on the following DATA_W-1 edges.
// Backpressure: none; load is ignored by the caller once tx_loaded is set, clr aborts at once.
module spi_miso_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] load_dat,
    output logic              miso,
    output logic              tx_loaded
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic              done
`endif
);
    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sh_q, sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              miso_q, miso_d;
    logic              loaded_q, loaded_d;

    // Next-state: clear beats load, load beats shifting; MISO idles low
    always_comb begin
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        miso_d   = 1'b0;
        loaded_d = loaded_q;
        if (clr) begin
            sh_d     = '0;
            cnt_d    = '0;
            loaded_d = 1'b0;
        end else if (load) begin
            miso_d   = load_dat[DATA_W-1];
            sh_d     = load_dat << 1;
            cnt_d    = CW'(DATA_W - 1);
            loaded_d = 1'b1;
        end else if (cnt_q != '0) begin
            miso_d = sh_q[DATA_W-1];
            sh_d   = sh_q << 1;
            cnt_d  = cnt_q - 1'b1;
        end
    end

    // Shift register, remaining-bit count and registered MISO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q     <= '0;
            cnt_q    <= '0;
            miso_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            miso_q   <= miso_d;
            loaded_q <= loaded_d;
        end
    end

    assign miso      = miso_q;
    assign tx_loaded = loaded_q;
`ifdef SPI_FRAME_ERR_EN
    // All DATA_W bits have been placed on MISO
    assign done = loaded_q && (cnt_q == '0);
`endif

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 10-bit frames to the RAM, serialises read data back on MISO.
// Latency: rx_valid the edge after the 10th bit is sampled; MISO MSB the edge after tx_valid.
// Backpressure: none; SS_n high aborts a frame. Optional SPI_FRAME_ERR_EN adds a frame_err abort pulse.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_slave_if_if.slave  bus
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic           frame_err
`endif
);
    // Counter value once all payload bits after the first command bit are in
    localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);

    spi_state_e         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [FRAME_W-2:0] shift_q, shift_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rd_addr_seen_q, rd_addr_seen_d;

    logic ser_clr, ser_load, ser_miso, tx_loaded;
    logic frame_done;

    assign frame_done = (cnt_q == LAST_BIT);

    // Frame FSM, bit assembly and read-address/read-data pairing
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_seen_d = rd_addr_seen_q;
        if (bus.SS_n) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = CHK_CMD;
                CHK_CMD: begin
                    shift_d = {shift_q[FRAME_W-3:0], bus.MOSI};
                    cnt_d   = '0;
                    if (!bus.MOSI)          state_d = WRITE;
                    else if (rd_addr_seen_q) state_d = READ_DATA;
                    else                     state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    // Once saturated, MOSI is ignored until SS_n rises
                    if (!frame_done) begin
                        shift_d = {shift_q[FRAME_W-3:0], bus.MOSI};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == LAST_BIT - 4'd1) begin
                            rx_data_d  = {shift_q, bus.MOSI};
                            rx_valid_d = 1'b1;
                            if (state_q == READ_ADD)       rd_addr_seen_d = 1'b1;
                            else if (state_q == READ_DATA) rd_addr_seen_d = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Frame state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_seen_q <= rd_addr_seen_d;
        end
    end

    // Only the first RAM response after a completed read-data frame is taken
    assign ser_clr  = bus.SS_n || (state_q == IDLE);
    assign ser_load = (state_q == READ_DATA) && frame_done && bus.tx_valid && !tx_loaded;

`ifdef SPI_FRAME_ERR_EN
    logic ser_done;
    logic frame_err_q, frame_err_d;

    // Abort before the frame or its read response has fully transferred
    always_comb begin
        frame_err_d = 1'b0;
        if (bus.SS_n) begin
            if ((state_q != IDLE) && !frame_done)
                frame_err_d = 1'b1;
            else if ((state_q == READ_DATA) && !ser_done)
                frame_err_d = 1'b1;
        end
    end

    // Registered one-cycle abort pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_err_q <= 1'b0;
        else        frame_err_q <= frame_err_d;
    end

    assign frame_err = frame_err_q;
`endif

    spi_miso_serializer #(.DATA_W(DATA_W)) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (ser_clr),
        .load      (ser_load),
        .load_dat  (bus.tx_data),
        .miso      (ser_miso),
        .tx_loaded (tx_loaded)
`ifdef SPI_FRAME_ERR_EN
        ,
        .done      (ser_done)
`endif
    );

    assign bus.MISO     = ser_miso;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: directed frame table, randomized frames, reset mid-frame.
// The reference is a transaction-level model of the slave plus the RAM it feeds.
// Optional SPI_FRAME_ERR_EN also checks frame_err.
module tb_spi_slave_if;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_slave_if_if #(.FRAME_W(10), .DATA_W(8)) bus ();

`ifdef SPI_FRAME_ERR_EN
    logic frame_err;
    spi_slave_if dut (.clk(clk), .rst_n(rst_n), .bus(bus), .frame_err(frame_err));
`else
    spi_slave_if dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: RAM contents and pointers, slave pairing flag, last delivered word
    logic [7:0] mem [256];
    logic [7:0] wr_addr_m;
    logic [7:0] rd_addr_m;
    bit         rd_seen_m;
    logic [9:0] model_rx;

    typedef struct {
        logic [9:0] w;
        int         nbits;
        bit         give_tx;
        logic [9:0] exp_rx;
    } vec_t;

    vec_t tbl [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic check_outs(input bit e_miso, input bit e_rxv, input bit e_err);
        chk("miso", 32'(bus.MISO), 32'(e_miso));
        chk("rx_valid", 32'(bus.rx_valid), 32'(e_rxv));
        chk("rx_data", 32'(bus.rx_data), 32'(model_rx));
`ifdef SPI_FRAME_ERR_EN
        chk("frame_err", 32'(frame_err), 32'(e_err));
`endif
    endtask

    // One SS_n-low window: nbits frame bits, optional RAM response, then SS_n high
    task automatic run_frame(input logic [9:0] w, input int nbits, input bit give_tx);
        bit in_rd, ram_rsp, resp, err;
        logic [7:0] txd;
        in_rd   = w[9] && rd_seen_m;
        ram_rsp = 1'b0;
        txd     = 8'h00;
        bus.SS_n     = 1'b0;
        bus.MOSI     = 1'($urandom);
        bus.tx_valid = 1'b0;
        tick();
        check_outs(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI     = w[9-i];
            bus.tx_valid = 1'($urandom);
            bus.tx_data  = 8'($urandom);
            tick();
            if (i == 9) begin
                model_rx = w;
                if (w[9]) rd_seen_m = !in_rd;
                case (w[9:8])
                    2'b00:   wr_addr_m = w[7:0];
                    2'b01:   mem[wr_addr_m] = w[7:0];
                    2'b10:   rd_addr_m = w[7:0];
                    default: begin ram_rsp = 1'b1; txd = mem[rd_addr_m]; end
                endcase
            end
            check_outs(1'b0, i == 9, 1'b0);
        end
        resp = (nbits == 10) && in_rd && ram_rsp && give_tx;
        err  = (nbits < 10) || (in_rd && !resp);
        if (nbits == 10) begin
            if (ram_rsp && give_tx) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = txd;
                bus.MOSI     = 1'($urandom);
                tick();
                check_outs(resp ? txd[7] : 1'b0, 1'b0, 1'b0);
                for (int b = 6; b >= 0; b--) begin
                    bus.tx_valid = 1'($urandom);
                    bus.tx_data  = 8'($urandom);
                    bus.MOSI     = 1'($urandom);
                    tick();
                    check_outs(resp ? txd[b] : 1'b0, 1'b0, 1'b0);
                end
            end
            for (int k = 0; k < 3; k++) begin
                bus.tx_valid = (in_rd && !resp) ? 1'b0 : 1'($urandom);
                bus.tx_data  = 8'($urandom);
                bus.MOSI     = 1'($urandom);
                tick();
                check_outs(1'b0, 1'b0, 1'b0);
            end
        end
        bus.SS_n     = 1'b1;
        bus.tx_valid = 1'b0;
        tick();
        check_outs(1'b0, 1'b0, err);
        tick();
        check_outs(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        wr_addr_m = 8'h00;
        rd_addr_m = 8'h00;
        rd_seen_m = 1'b0;
        model_rx  = 10'h000;

        rst_n        = 1'b0;
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        #12;
        check_outs(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_outs(1'b0, 1'b0, 1'b0);

        // Directed frames: {word, bits sent before SS_n rises, RAM answers, rx_data afterwards}
        tbl[0]  = '{10'h03C, 10, 1'b0, 10'h03C};  // write addr 0x3C
        tbl[1]  = '{10'h1A5, 10, 1'b0, 10'h1A5};  // mem[0x3C] = 0xA5
        tbl[2]  = '{10'h23C, 10, 1'b0, 10'h23C};  // read addr -> READ_ADD
        tbl[3]  = '{10'h300, 10, 1'b1, 10'h300};  // read data -> MISO 0xA5
        tbl[4]  = '{10'h3C1, 10, 1'b1, 10'h3C1};  // bit9=1 with no addr seen -> READ_ADD, response ignored
        tbl[5]  = '{10'h155,  5, 1'b0, 10'h3C1};  // abort after 5 bits
        tbl[6]  = '{10'h077, 10, 1'b0, 10'h077};  // write addr 0x77
        tbl[7]  = '{10'h1C3, 10, 1'b0, 10'h1C3};  // mem[0x77] = 0xC3
        tbl[8]  = '{10'h277, 10, 1'b0, 10'h277};  // addr seen -> READ_DATA, no RAM answer
        tbl[9]  = '{10'h277, 10, 1'b0, 10'h277};  // READ_ADD again
        tbl[10] = '{10'h355, 10, 1'b1, 10'h355};  // READ_DATA -> MISO 0xC3
        tbl[11] = '{10'h300,  0, 1'b0, 10'h355};  // abort in CHK_CMD
        for (int i = 0; i < 12; i++) begin
            run_frame(tbl[i].w, tbl[i].nbits, tbl[i].give_tx);
            chk($sformatf("tbl_rx[%0d]", i), 32'(bus.rx_data), 32'(tbl[i].exp_rx));
        end

        // Randomized frames, some aborted, some without a RAM answer
        for (int n = 0; n < 60; n++) begin
            logic [9:0] w;
            int nb;
            w  = 10'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 10;
            run_frame(w, nb, $urandom_range(0, 3) != 0);
        end

        // Reset in the middle of a frame with a read address pending
        if (!rd_seen_m) run_frame(10'h2AB, 10, 1'b0);
        bus.SS_n = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.MOSI = 1'($urandom);
            tick();
            check_outs(1'b0, 1'b0, 1'b0);
        end
        #2;
        rst_n    = 1'b0;
        bus.SS_n = 1'b1;
        #1;
        model_rx  = 10'h000;
        rd_seen_m = 1'b0;
        check_outs(1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check_outs(1'b0, 1'b0, 1'b0);
        run_frame(10'h3FF, 10, 1'b1);  // pairing flag was reset: READ_ADD, no MISO
        run_frame(10'h3FF, 10, 1'b1);  // now READ_DATA with a response

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
SPI slave front end that feeds the single-port SPI RAM. It deserialises MOSI into 10-bit command/data words (bits [9:8] command, [7:0] payload) and pulses rx_valid toward the RAM. On a read-data command it captures the RAM's tx_data/tx_valid response and serialises it back on MISO. The system clock clk doubles as the SPI bit clock: one MOSI bit per clk rising edge while SS_n is low.

Parameters:
FRAME_W, 10, width of rx_data word (2 command bits plus DATA_W payload)
DATA_W, 8, width of tx_data and of the MISO response

Ports:
clk  in  1  system clock and SPI bit clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
SS_n  in  1  slave select, active low; high aborts or ends a frame
MOSI  in  1  serial data in, MSB first
MISO  out  1  serial data out, MSB first
rx_data  out  FRAME_W  assembled word to RAM din
rx_valid  out  1  one-cycle strobe: rx_data holds a complete frame
tx_data  in  DATA_W  read data from RAM
tx_valid  in  1  RAM read data valid

Behaviour:
- Reset: MISO=0, rx_data=0, rx_valid=0, state=IDLE, bit counter=0, rd_addr_seen=0, tx_loaded=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- SS_n high in any state -> IDLE next edge. Partial frame discarded: no rx_valid, counters cleared, rx_data and rd_addr_seen unchanged. MISO=0.
- IDLE: SS_n low -> CHK_CMD. No bit is sampled on this edge.
- CHK_CMD: sample MOSI as frame bit 9. 0 -> WRITE. 1 and rd_addr_seen=0 -> READ_ADD. 1 and rd_addr_seen=1 -> READ_DATA.
- WRITE, READ_ADD, READ_DATA: shift in 9 more bits (bits 8..0), MSB first.
- On the 10th-bit edge: rx_data <= assembled word and rx_valid <= 1 for exactly one cycle.
  - READ_ADD: set rd_addr_seen.
  - READ_DATA: clear rd_addr_seen.
- After the frame, MOSI is ignored until SS_n goes high. rx_data holds its value until the next completed frame.
- Command bits [9:8] are forwarded verbatim from MOSI. The slave does not reinterpret bit 8.
- READ_DATA response:
  - After the frame completes, the first edge with tx_valid=1 and tx_loaded=0 loads the shift register with tx_data, sets tx_loaded and drives MISO=tx_data[7].
  - The next 7 edges drive bits 6..0. MISO then returns to 0.
  - Further tx_valid assertions in the same frame are ignored. tx_loaded clears in IDLE.
  - Typical latency: rx_valid edge+1 -> tx_valid, +1 -> first MISO bit.
- tx_valid outside READ_DATA (post-frame) is ignored.
- Bit counter: 4 bits, counts 0..9 and saturates. No wrap.
- Reset asserted mid-frame: immediate return to reset values, including rd_addr_seen.

Optional Feature:
SPI_FRAME_ERR_EN
- Defined: adds output port frame_err (1 bit, reset 0). It pulses high for one cycle when SS_n rises in CHK_CMD, WRITE, READ_ADD or READ_DATA before the 10th bit, or in READ_DATA before the 8th MISO bit is shifted.
- Undefined: port and logic absent. Aborts are silent.

Decomposition:
- Package spi_pkg: state encoding typedef (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA); command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11; FRAME_W and DATA_W defaults.
- One sub-module, spi_miso_serializer: load, 8-bit shift, busy/done, MISO output.

Test Plan:
- Reset then SS_n low, MOSI=0_0_0x3C (10 bits) -> rx_data=10'h03C and one rx_valid pulse on the 10th edge; MISO stays 0.
- Second frame 0_1_0xA5 -> rx_data=10'h1A5 and rx_valid pulse; RAM mem[0x3C]=0xA5.
- Frame 1_0_0x3C -> state READ_ADD, rx_data=10'h23C, rd_addr_seen=1.
- Frame 1_1_0x00 -> state READ_DATA, rx_data=10'h300; tx_valid next cycle; MISO = 1,0,1,0,0,1,0,1 (0xA5) on 8 consecutive edges, then 0; rd_addr_seen=0.
- Frame 1_x sent with rd_addr_seen=0 -> goes to READ_ADD, not READ_DATA.
- SS_n raised after 5 bits -> no rx_valid, state IDLE, next full frame decodes correctly. With SPI_FRAME_ERR_EN, frame_err pulses once.
